// File: rtl/gray_code_pkg.sv
// Shared Gray-code helpers: encode, decode and all-ones/zero constants.
// Latency: none (functions and constants only).
// Backpressure: not applicable.
//
// The functions work on a fixed maximum-width word. Callers zero-extend
// narrower values on the way in and truncate on the way out. Leading zeros
// encode and decode to leading zeros, so every width up to GRAY_MAX_WIDTH
// shares one definition.
package gray_code_pkg;

  localparam int GRAY_MAX_WIDTH = 64;

  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  localparam gray_word_t GRAY_ZERO = '0;

  // All-ones mask covering the low `width` bits.
  function automatic gray_word_t gray_ones(input int width);
    return {GRAY_MAX_WIDTH{1'b1}} >> (GRAY_MAX_WIDTH - width);
  endfunction

  // Reflected binary Gray encode.
  function automatic gray_word_t gray_encode(input gray_word_t binary);
    return binary ^ (binary >> 1);
  endfunction

  // Gray decode: each binary bit is the XOR of all Gray bits from the MSB
  // down to that position.
  function automatic gray_word_t gray_decode(input gray_word_t gray);
    gray_word_t binary;
    binary[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      binary[i] = binary[i+1] ^ gray[i];
    end
    return binary;
  endfunction

endpackage

// File: rtl/binary_to_gray_reflected.sv
// Combinational WORD_WIDTH binary to reflected-Gray encoder; holds no state.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   i_binary  in   WORD_WIDTH  binary value
//   o_gray    out  WORD_WIDTH  Gray encoding of i_binary
module binary_to_gray_reflected
  import gray_code_pkg::*;
#(
  parameter int WORD_WIDTH = 4
) (
  input  logic [WORD_WIDTH-1:0] i_binary,
  output logic [WORD_WIDTH-1:0] o_gray
);

  assign o_gray = WORD_WIDTH'(gray_encode(GRAY_MAX_WIDTH'(i_binary)));

endmodule

// File: rtl/gray_counter_reflected.sv
// Up-counter with registered binary and reflected-Gray outputs (CDC FIFO pointer).
// Latency: 1 cycle from clear/load/increment to binary_out, gray_out and wrap_out.
// Backpressure: none; every request is acted on in the cycle it is seen.
//
// Ports:
//   clock       in   1           rising-edge clock
//   reset_n     in   1           asynchronous active-low reset
//   clear       in   1           synchronous return to INITIAL_COUNT (highest priority)
//   load        in   1           synchronous load of load_value
//   load_value  in   WORD_WIDTH  binary value to load
//   increment   in   1           advance the count by one (lowest priority)
//   binary_out  out  WORD_WIDTH  registered binary count
//   gray_out    out  WORD_WIDTH  registered Gray encoding of binary_out (CDC-safe)
//   wrap_out    out  1           one-cycle pulse after an increment from all-ones
//
// WORD_WIDTH must be >= 2 and INITIAL_COUNT < 2**WORD_WIDTH.
module gray_counter_reflected
  import gray_code_pkg::*;
#(
  parameter int WORD_WIDTH    = 4,
  parameter int INITIAL_COUNT = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] load_value,
  input  logic                  increment,
  output logic [WORD_WIDTH-1:0] binary_out,
  output logic [WORD_WIDTH-1:0] gray_out,
  output logic                  wrap_out
);

  localparam logic [WORD_WIDTH-1:0] CNT_ONES  = WORD_WIDTH'(gray_ones(WORD_WIDTH));
  localparam logic [WORD_WIDTH-1:0] INIT_BIN  = WORD_WIDTH'(INITIAL_COUNT);
  localparam logic [WORD_WIDTH-1:0] INIT_GRAY =
    WORD_WIDTH'(gray_encode(GRAY_MAX_WIDTH'(INIT_BIN)));

  logic [WORD_WIDTH-1:0] r_binary;
  logic [WORD_WIDTH-1:0] r_gray;
  logic                  r_wrap;

  logic [WORD_WIDTH-1:0] w_next_binary;
  logic [WORD_WIDTH-1:0] w_next_gray;
  logic                  w_next_wrap;

  // Priority: clear > load > increment > hold. An increment arriving with
  // clear or load is dropped.
  always_comb begin
    w_next_binary = r_binary;
    w_next_wrap   = 1'b0;
    if (clear) begin
      w_next_binary = INIT_BIN;
    end else if (load) begin
      w_next_binary = load_value;
    end else if (increment) begin
      w_next_binary = r_binary + WORD_WIDTH'(1);
      w_next_wrap   = (r_binary == CNT_ONES);
    end
  end

  // Gray is encoded from the next count and registered alongside it, so the
  // Gray output comes straight from a flop and cannot glitch.
  binary_to_gray_reflected #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_encoder (
    .i_binary (w_next_binary),
    .o_gray   (w_next_gray)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_binary <= INIT_BIN;
      r_gray   <= INIT_GRAY;
      r_wrap   <= 1'b0;
    end else begin
      r_binary <= w_next_binary;
      r_gray   <= w_next_gray;
      r_wrap   <= w_next_wrap;
    end
  end

  assign binary_out = r_binary;
  assign gray_out   = r_gray;
  assign wrap_out   = r_wrap;

endmodule

// File: tb/tb_gray_counter_reflected.sv
module tb_gray_counter_reflected;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       load;
  logic [3:0] load_value;
  logic       increment;

  logic [3:0] bin_o  [2];
  logic [3:0] gray_o [2];
  logic       wrap_o [2];

  int total = 0;
  int bad   = 0;

  // Instance 0 uses INITIAL_COUNT=0, instance 1 uses INITIAL_COUNT=3.
  gray_counter_reflected #(.WORD_WIDTH(4), .INITIAL_COUNT(0)) dut0 (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .increment  (increment),
    .binary_out (bin_o[0]),
    .gray_out   (gray_o[0]),
    .wrap_out   (wrap_o[0])
  );

  gray_counter_reflected #(.WORD_WIDTH(4), .INITIAL_COUNT(3)) dut3 (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .increment  (increment),
    .binary_out (bin_o[1]),
    .gray_out   (gray_o[1]),
    .wrap_out   (wrap_o[1])
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Gray table built by reflection: the second half of each order is the
  // first half mirrored with the new top bit set.
  int gtab [16];

  initial begin
    gtab[0] = 0;
    gtab[1] = 1;
    for (int n = 1; n < 4; n++) begin
      for (int i = 0; i < (1 << n); i++) begin
        gtab[(1 << (n + 1)) - 1 - i] = gtab[i] | (1 << n);
      end
    end
  end

  function automatic int gray_index(input int g);
    for (int j = 0; j < 16; j++) begin
      if (gtab[j] == g) return j;
    end
    return -1;
  endfunction

  // Behavioural model: plain modular arithmetic on integers.
  int init_cnt [2] = '{0, 3};
  int m_bin    [2] = '{0, 3};
  int m_wrap   [2] = '{0, 0};
  int m_kind = 3;  // 0 hold, 1 increment only, 2 clear/load, 3 reset

  always @(posedge clock or negedge reset_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_bin[k]  = init_cnt[k];
        m_wrap[k] = 0;
      end else if (clear) begin
        m_bin[k]  = init_cnt[k];
        m_wrap[k] = 0;
      end else if (load) begin
        m_bin[k]  = int'(load_value);
        m_wrap[k] = 0;
      end else if (increment) begin
        m_wrap[k] = (m_bin[k] == 15) ? 1 : 0;
        m_bin[k]  = (m_bin[k] + 1) % 16;
      end else begin
        m_wrap[k] = 0;
      end
    end
    if (!reset_n)          m_kind = 3;
    else if (clear || load) m_kind = 2;
    else if (increment)     m_kind = 1;
    else                    m_kind = 0;
  end

  // Compare process: every falling edge, both instances against the model.
  logic [3:0] prev_gray [2];
  bit         have_prev = 1'b0;

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("model_bin%0d", k), int'(bin_o[k]), m_bin[k]);
      check($sformatf("model_gray%0d", k), int'(gray_o[k]), gtab[m_bin[k]]);
      check($sformatf("model_wrap%0d", k), int'(wrap_o[k]), m_wrap[k]);
      check($sformatf("decode%0d", k), gray_index(int'(gray_o[k])), int'(bin_o[k]));
      if (have_prev && (m_kind == 0 || m_kind == 1)) begin
        check($sformatf("bitchange%0d", k), $countones(gray_o[k] ^ prev_gray[k]), m_kind);
      end
      prev_gray[k] = gray_o[k];
    end
    have_prev = (m_kind != 3);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int gseq [17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

  initial begin
    reset_n    = 1'b0;
    clear      = 1'b0;
    load       = 1'b0;
    load_value = 4'd0;
    increment  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Reset values.
    check("rst_bin0", int'(bin_o[0]), 0);
    check("rst_gray0", int'(gray_o[0]), 0);
    check("rst_wrap0", int'(wrap_o[0]), 0);
    check("rst_bin3", int'(bin_o[1]), 3);
    check("rst_gray3", int'(gray_o[1]), 2);

    // Full Gray sequence with wrap.
    increment = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("seq_gray[%0d]", i + 1), int'(gray_o[0]), gseq[i + 1]);
      check($sformatf("seq_bin[%0d]", i + 1), int'(bin_o[0]), (i + 1) % 16);
      check($sformatf("seq_wrap[%0d]", i + 1), int'(wrap_o[0]), (i == 15) ? 1 : 0);
    end

    // Load beats increment.
    increment  = 1'b0;
    load       = 1'b1;
    load_value = 4'd5;
    tick();
    check("pre_load_bin", int'(bin_o[0]), 5);
    load_value = 4'd12;
    increment  = 1'b1;
    tick();
    check("load_inc_bin", int'(bin_o[0]), 12);
    check("load_inc_gray", int'(gray_o[0]), 4'b1010);
    check("load_inc_wrap", int'(wrap_o[0]), 0);

    // Clear beats load and increment.
    clear      = 1'b1;
    load_value = 4'd9;
    tick();
    check("clr_all_bin3", int'(bin_o[1]), 3);
    check("clr_all_gray3", int'(gray_o[1]), 4'b0010);
    check("clr_all_bin0", int'(bin_o[0]), 0);

    // Asynchronous reset between edges at count 7.
    clear      = 1'b0;
    increment  = 1'b0;
    load_value = 4'd7;
    tick();
    load = 1'b0;
    check("pre_rst_bin", int'(bin_o[0]), 7);
    #1 reset_n = 1'b0;
    #1;
    check("async_bin0", int'(bin_o[0]), 0);
    check("async_gray0", int'(gray_o[0]), 0);
    check("async_wrap0", int'(wrap_o[0]), 0);
    check("async_bin3", int'(bin_o[1]), 3);
    check("async_gray3", int'(gray_o[1]), 2);
    #1 reset_n = 1'b1;

    // Count at 15 with increment and clear: no wrap pulse.
    tick();
    load       = 1'b1;
    load_value = 4'd15;
    tick();
    load      = 1'b0;
    clear     = 1'b1;
    increment = 1'b1;
    tick();
    check("clr15_bin0", int'(bin_o[0]), 0);
    check("clr15_wrap0", int'(wrap_o[0]), 0);
    check("clr15_bin3", int'(bin_o[1]), 3);
    check("clr15_wrap3", int'(wrap_o[1]), 0);
    clear     = 1'b0;
    increment = 1'b0;

    // Randomly toggled increment with occasional load/clear; model checks.
    for (int i = 0; i < 1000; i++) begin
      int r;
      r          = int'($urandom_range(0, 31));
      clear      = (r == 0);
      load       = (r == 1);
      load_value = 4'($urandom_range(0, 15));
      increment  = 1'($urandom_range(0, 1));
      tick();
    end

    clear     = 1'b0;
    load      = 1'b0;
    increment = 1'b0;
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
